// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and supervises memory waits with a timeout.
// Optional feature: define MCTRL_PERF_CNT_EN to build the cycles/instret
// performance counters; otherwise both outputs are tied to zero.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        reg_write,
  output logic [6:0]  imm_opcode,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  state,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd15
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic [TO_W-1:0] to_cnt;
  logic            stall;
  logic            expire;
  logic            set_ill;
  logic            set_to;
  logic [2:0]      funct3;
  logic            unused_instr;

  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};
  assign state        = st_q;

  // Next-state selection, wait supervision and sticky-flag set conditions
  always_comb begin
    st_d    = st_q;
    set_ill = 1'b0;
    set_to  = 1'b0;
    stall   = ((st_q == FETCH) || (st_q == MEM_RD) || (st_q == MEM_WR)) && !mem_ready;
    expire  = stall && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    case (st_q)
      FETCH, MEM_RD, MEM_WR: begin
        if (mem_ready) begin
          case (st_q)
            FETCH:   st_d = DECODE;
            MEM_RD:  st_d = MEM_WB;
            default: st_d = FETCH;
          endcase
        end else if (expire) begin
          st_d   = TRAP;
          set_to = 1'b1;
        end
      end
      DECODE: begin
        case (instr[6:0])
          OP_R:              st_d = EXEC_R;
          OP_I:              st_d = EXEC_I;
          OP_LOAD, OP_STORE: st_d = MEM_ADDR;
          OP_BRANCH: begin
            if (funct3[2:1] == 2'b00) begin
              st_d = BRANCH;
            end else begin
              st_d    = TRAP;
              set_ill = 1'b1;
            end
          end
          default: begin
            st_d    = TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      MEM_ADDR: st_d = (imm_opcode == OP_STORE) ? MEM_WR : MEM_RD;
      EXEC_R, EXEC_I: st_d = ALU_WB;
      ALU_WB, MEM_WB, BRANCH: st_d = FETCH;
      default: st_d = TRAP;
    endcase
  end

  // State, timeout counter, decoded opcode and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= FETCH;
      to_cnt     <= '0;
      imm_opcode <= '0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q) begin
        to_cnt <= '0;
      end else if (stall) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (st_q == DECODE) begin
        imm_opcode <= instr[6:0];
      end
      if (set_ill) begin
        illegal <= 1'b1;
      end
      if (set_to) begin
        timeout <= 1'b1;
      end
    end
  end

  // Moore control decode; strobes are held low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    if (rst_n) begin
      case (st_q)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b10;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        ALU_WB: begin
          reg_write  = 1'b1;
          result_src = 2'b10;
        end
        BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          result_src = 2'b10;
          pc_write   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        end
        default: ;
      endcase
    end
  end

`ifdef MCTRL_PERF_CNT_EN
  logic retire;

  assign retire = (st_q == ALU_WB) || (st_q == MEM_WB) || (st_q == BRANCH) ||
                  ((st_q == MEM_WR) && mem_ready);

  // Performance counters: live cycles and retired instructions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycles  <= '0;
      instret <= '0;
    end else begin
      if (st_q != TRAP) begin
        cycles <= cycles + 32'd1;
      end
      if (retire) begin
        instret <= instret + 32'd1;
      end
    end
  end
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// expected per-cycle response, a negedge monitor pops and compares it.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [6:0]  imm_opcode;
  logic        illegal, timeout;
  logic [3:0]  state;
  logic [31:0] instret, cycles;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write),
    .imm_opcode(imm_opcode), .illegal(illegal), .timeout(timeout),
    .state(state), .instret(instret), .cycles(cycles)
  );

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_write, pc_write;
    logic [1:0] a, b, op, rs;
    logic       reg_write;
  } stb_t;

  typedef struct packed {
    stb_t        s;
    logic        full;
    logic [3:0]  st;
    logic        ill, to;
    logic [6:0]  imm;
    logic [31:0] ir, cy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  logic [31:0] cur_instr = '0;
  logic        exp_ill = 1'b0;
  logic        exp_to = 1'b0;
  logic [6:0]  exp_imm = '0;
  logic [31:0] exp_ir = '0;
  logic [31:0] exp_cy = '0;

  // Control table per state, written out from the state descriptions
  function automatic stb_t moore(input logic [3:0] st);
    stb_t v;
    v = '0;
    case (st)
      4'd0: begin v.mem_req = 1'b1; v.b = 2'b10; end
      4'd1: begin v.a = 2'b01; v.b = 2'b01; end
      4'd2: begin v.a = 2'b10; v.b = 2'b01; end
      4'd3: begin v.mem_req = 1'b1; v.adr_src = 1'b1; end
      4'd4: begin v.reg_write = 1'b1; v.rs = 2'b01; end
      4'd5: begin v.mem_req = 1'b1; v.mem_we = 1'b1; v.adr_src = 1'b1; end
      4'd6: begin v.a = 2'b10; v.op = 2'b10; end
      4'd7: begin v.a = 2'b10; v.b = 2'b01; v.op = 2'b10; end
      4'd8: begin v.reg_write = 1'b1; v.rs = 2'b10; end
      4'd9: begin v.a = 2'b10; v.op = 2'b01; v.rs = 2'b10; end
      default: ;
    endcase
    return v;
  endfunction

  // One clock of stimulus plus the expected response for that cycle
  task automatic step(input logic r, input logic rdy, input logic z, input logic [3:0] st,
                      input logic xw, input logic full, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = r;
    mem_ready = rdy;
    zero      = z;
    instr     = cur_instr;
    e = '0;
    if (r) begin
      e.s = moore(st);
      if (st == 4'd0) begin
        e.s.ir_write = xw;
        e.s.pc_write = xw;
      end
      if (st == 4'd9) e.s.pc_write = xw;
    end
    e.full = full;
    e.st   = st;
    e.ill  = exp_ill;
    e.to   = exp_to;
    e.imm  = exp_imm;
`ifdef MCTRL_PERF_CNT_EN
    e.ir = exp_ir;
    e.cy = exp_cy;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!r) begin
      exp_ill = 1'b0;
      exp_to  = 1'b0;
      exp_imm = '0;
      exp_ir  = '0;
      exp_cy  = '0;
    end else begin
      if (st != 4'd15) exp_cy = exp_cy + 32'd1;
      if (st == 4'd8 || st == 4'd4 || st == 4'd9 || (st == 4'd5 && rdy)) exp_ir = exp_ir + 32'd1;
      if (st == 4'd1) exp_imm = cur_instr[6:0];
    end
  endtask

  exp_t        mon_e;
  string       mon_n;
  stb_t        act_s;
  logic [76:0] act_r;
  logic [76:0] exp_r;

  // Monitor: compare each presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      act_s = {mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
               alu_op, result_src, reg_write};
      checks = checks + 1;
      if (act_s !== mon_e.s) begin
        errors = errors + 1;
        $display("FAIL %s strobes: got %h expected %h", mon_n, act_s, mon_e.s);
      end
      if (mon_e.full) begin
        act_r = {state, illegal, timeout, imm_opcode, instret, cycles};
        exp_r = {mon_e.st, mon_e.ill, mon_e.to, mon_e.imm, mon_e.ir, mon_e.cy};
        checks = checks + 1;
        if (act_r !== exp_r) begin
          errors = errors + 1;
          $display("FAIL %s regs(state,ill,to,imm,instret,cycles): got %h expected %h",
                   mon_n, act_r, exp_r);
        end
      end
    end
  end

  initial begin
    // reset with memory ready
    step(0, 1, 0, 4'd0, 0, 0, "rst0");
    step(0, 1, 0, 4'd0, 0, 1, "rst1");
    step(0, 1, 0, 4'd0, 0, 1, "rst2");
    // R-type add
    cur_instr = 32'h002081B3;
    step(1, 1, 0, 4'd0, 1, 1, "r_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "r_dec");
    step(1, 1, 0, 4'd6, 0, 1, "r_exec");
    step(1, 1, 0, 4'd8, 0, 1, "r_wb");
    // I-type addi
    cur_instr = 32'h00108093;
    step(1, 1, 0, 4'd0, 1, 1, "i_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "i_dec");
    step(1, 1, 0, 4'd7, 0, 1, "i_exec");
    step(1, 1, 0, 4'd8, 0, 1, "i_wb");
    // load with two wait cycles
    cur_instr = 32'h0000A103;
    step(1, 1, 0, 4'd0, 1, 1, "lw_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "lw_dec");
    step(1, 1, 0, 4'd2, 0, 1, "lw_addr");
    step(1, 0, 0, 4'd3, 0, 1, "lw_wait1");
    step(1, 0, 0, 4'd3, 0, 1, "lw_wait2");
    step(1, 1, 0, 4'd3, 0, 1, "lw_rdy");
    step(1, 1, 0, 4'd4, 0, 1, "lw_wb");
    // store: ready arrives exactly on the timeout cycle and must win
    cur_instr = 32'h0020A023;
    step(1, 1, 0, 4'd0, 1, 1, "sw_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "sw_dec");
    step(1, 1, 0, 4'd2, 0, 1, "sw_addr");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd5, 0, 1, "sw_wait");
    step(1, 1, 0, 4'd5, 0, 1, "sw_thresh_rdy");
    // beq taken / not taken
    cur_instr = 32'h00208463;
    step(1, 1, 0, 4'd0, 1, 1, "beq_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "beq_dec");
    step(1, 1, 1, 4'd9, 1, 1, "beq_taken");
    step(1, 1, 0, 4'd0, 1, 1, "beq_fetch2");
    step(1, 1, 0, 4'd1, 0, 1, "beq_dec2");
    step(1, 1, 0, 4'd9, 0, 1, "beq_not_taken");
    // bne taken / not taken
    cur_instr = 32'h00209463;
    step(1, 1, 0, 4'd0, 1, 1, "bne_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "bne_dec");
    step(1, 1, 0, 4'd9, 1, 1, "bne_taken");
    step(1, 1, 0, 4'd0, 1, 1, "bne_fetch2");
    step(1, 1, 0, 4'd1, 0, 1, "bne_dec2");
    step(1, 1, 1, 4'd9, 0, 1, "bne_not_taken");
    // reset in the middle of a load wait drops the request at once
    cur_instr = 32'h0000A103;
    step(1, 1, 0, 4'd0, 1, 1, "mid_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "mid_dec");
    step(1, 1, 0, 4'd2, 0, 1, "mid_addr");
    step(1, 0, 0, 4'd3, 0, 1, "mid_wait");
    step(0, 0, 0, 4'd0, 0, 0, "mid_rst");
    step(0, 1, 0, 4'd0, 0, 1, "mid_rst_hold");
    // illegal opcode traps and stays quiet until reset
    cur_instr = 32'h0000007F;
    step(1, 1, 0, 4'd0, 1, 1, "ill_fetch");
    step(1, 1, 0, 4'd1, 0, 1, "ill_dec");
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 1, 0, 4'd15, 0, 1, "ill_trap");
    step(0, 1, 0, 4'd0, 0, 0, "ill_rst0");
    step(0, 1, 0, 4'd0, 0, 1, "ill_rst1");
    // fetch timeout after four wait cycles
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd0, 0, 1, "to_wait");
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'd15, 0, 1, "to_trap");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
